uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the board UART between several byte producers, such as the CPU core and a debug monitor, and buffers traffic in both directions. On transmit it arbitrates round-robin with per-packet locking, so a multi-byte string from one requester is never interleaved with another's. Accepted bytes go through a small TX FIFO that drives the UART AXI-stream input. On receive it provides a one-byte holding register with proper valid/ready backpressure, replacing the ad-hoc edge-triggered xmit/recv flops in the board top level. It sits in the `serclk` domain between the UART instance and the requester logic; crossing into `serclk` is the caller's responsibility.

## Interface
- `NREQ`, 2: number of TX requesters (2..4).
- `DEPTH`, 4: TX FIFO entries; must be a power of two, 2..16.
- `clk` in 1: single clock, `serclk` domain.
- `n_rst` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: requester i has a byte.
- `req_data` in 8*NREQ: byte of requester i at [8i+7:8i].
- `req_last` in NREQ: byte of requester i ends its packet.
- `req_ready` out NREQ: one-hot; byte of requester i is accepted this cycle.
- `m_tdata` out 8: to UART `input_axis_tdata`.
- `m_tvalid` out 1: to UART `input_axis_tvalid`.
- `m_tready` in 1: from UART `input_axis_tready`.
- `s_tdata` in 8: from UART `output_axis_tdata`.
- `s_tvalid` in 1: from UART `output_axis_tvalid`.
- `s_tready` out 1: to UART `output_axis_tready`.
- `rx_data` out 8: held received byte.
- `rx_valid` out 1: `rx_data` is valid.
- `rx_ack` in 1: consumer takes `rx_data` this cycle.
- `tx_count` out clog2(DEPTH+1): TX FIFO occupancy.
- `tx_locked` out 1: a packet lock is held.
- `tx_owner` out clog2(NREQ) (min 1): current lock owner, or the last granted requester.

## Operation
- **Arbiter FSM states**
  - IDLE: no lock is held.
  - LOCKED: requester `owner` holds the lock.
- **Rotation pointer `rr`**: `rr` is in 0..NREQ-1.
- **Accept condition**: a transfer of requester i happens when `req_valid[i] & req_ready[i]`.
- **Push gating**: push is allowed only when `tx_count < DEPTH`, using the registered count. A pop in the same cycle does not free space for that cycle's push.
- **IDLE, grant selection**
  - Candidate is the first i with `req_valid[i]` when scanning rr, rr+1, … mod NREQ.
  - If push is allowed, `req_ready[candidate]` = 1 and the byte is pushed.
  - If the accepted byte has `req_last=0`: next state LOCKED, `owner`=i.
  - If `req_last=1`: stay IDLE.
  - On any accepted byte, `rr` becomes (i+1) mod NREQ.
- **LOCKED**
  - Only `owner` may be granted; other requests are ignored.
  - When the owner's accepted byte has `req_last=1`: go to IDLE and set `rr`=(owner+1) mod NREQ.
  - The lock persists indefinitely while the owner idles. There is no timeout, so requesters must terminate packets.
- **`req_ready` timing**: `req_ready` is combinational from `req_valid`, state, `rr` and `tx_count`. It never depends on `req_data`.
- **TX FIFO**
  - Circular buffer with `wr`/`rd` pointers of clog2(DEPTH) bits; pointers wrap naturally.
  - `m_tvalid` = (`tx_count` != 0). `m_tdata` = entry at `rd`.
  - Pop on `m_tvalid & m_tready`.
  - `tx_count` is +1 on push only, −1 on pop only, and unchanged when both occur.
  - `m_tdata` must stay stable while `m_tvalid & ~m_tready`.
- **RX holding register**
  - `s_tready` = ~`rx_valid` | `rx_ack`.
  - On `s_tvalid & s_tready`: load `rx_data` and set `rx_valid`=1. This includes a load in the same cycle as `rx_ack`; `rx_valid` then stays 1 with the new byte.
  - `rx_ack` with no load clears `rx_valid`.
  - `rx_ack` while `rx_valid`=0 is ignored.
  - No byte is ever dropped or overwritten.

## Timing
- **Reset values (n_rst low, asynchronous)**
  - State IDLE, `rr`=0, `owner`=0, pointers 0.
  - `tx_count`=0, `m_tvalid`=0, `tx_locked`=0, `tx_owner`=0.
  - `rx_valid`=0, `rx_data`=0, `s_tready`=1, `req_ready`=0.
  - `m_tdata` is 0 when the FIFO is empty after reset.
- **Reset mid-packet**: the lock and any buffered TX bytes are discarded. The first cycle after deassertion is a normal IDLE cycle.
- **TX latency**: a byte accepted in cycle N into an empty FIFO gives `m_tvalid`=1 and `m_tdata`=byte in N+1.
  - Peak throughput is 1 byte/cycle into the FIFO.
- **RX latency**: a byte accepted in cycle N gives `rx_valid`=1 in N+1.
- **Status outputs**: `tx_locked` and `tx_owner` are registered and reflect the state after the accepting edge.

## Test plan
1. **Round-robin**: after reset, NREQ=2, both requesters valid with `last`=1 each byte, `m_tready`=1 → grants alternate 0,1,0,1 and `m_tdata` shows 0x41,0x61,0x42,0x62 in that order.
2. **Packet lock**: req0 sends "ABC" (`last` on 'C') while req1 is valid throughout → req1 gets no grant until after 'C'. `tx_locked`=1 for 2 cycles, then req1 is granted the next cycle.
3. **FIFO full**: `m_tready`=0 with 5 single-byte pushes → 4 accepted, `tx_count`=4, `req_ready`=0 on the 5th. Raising `m_tready` for one cycle pops 0x41, and no push is accepted that same cycle.
4. **RX backpressure**: two bytes 0x55 and 0xAA with no `rx_ack` → `s_tready`=0 after 0x55 and `rx_data` holds 0x55. Pulsing `rx_ack` while 0xAA is valid loads 0xAA in the same cycle and `rx_valid` stays 1.
5. **Reset mid-packet**: assert `n_rst` low while req1 is locked with 3 bytes buffered → `tx_count`=0, `m_tvalid`=0 and `tx_locked`=0 immediately. After release, req0 is granted first (`rr`=0).

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester, UART AXI-stream, RX consumer and status signals for uart_tx_arbiter.
// The slave modport is the arbiter side; master is the side that drives the arbiter's inputs.
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic [7:0]        s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ack;
  logic [CW-1:0]     tx_count;
  logic              tx_locked;
  logic [OW-1:0]     tx_owner;

  modport slave (
    input  req_valid, req_data, req_last, m_tready, s_tdata, s_tvalid, rx_ack,
    output req_ready, m_tdata, m_tvalid, s_tready, rx_data, rx_valid,
           tx_count, tx_locked, tx_owner
  );

  modport master (
    output req_valid, req_data, req_last, m_tready, s_tdata, s_tvalid, rx_ack,
    input  req_ready, m_tdata, m_tvalid, s_tready, rx_data, rx_valid,
           tx_count, tx_locked, tx_owner
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking TX arbiter with a small TX FIFO toward the UART,
// plus a one-byte RX holding register with valid/ready backpressure.
module uart_tx_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [0:0] {IDLE, LOCKED} state_t;

  state_t          state, state_n;
  logic [OW-1:0]   rr, rr_n;
  logic [OW-1:0]   owner, owner_n;
  logic [OW-1:0]   sel;
  logic            found;
  logic            push;
  logic            pop;
  logic            push_ok;
  logic            sel_last;
  logic [7:0]      sel_data;
  logic [NREQ-1:0] ready;

  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr, rd;
  logic [CW-1:0]   count;

  logic [7:0]      rx_data_q;
  logic            rx_valid_q;
  logic            s_ready;
  logic            load;

  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] i);
    return (i == OW'(NREQ - 1)) ? '0 : i + OW'(1);
  endfunction

  // Space check uses the registered count only, so a same-cycle pop never frees a slot
  assign push_ok = (count < CW'(DEPTH));
  assign pop     = (count != '0) && bus.m_tready;

  // Arbiter next-state: pick a candidate, grant it if the FIFO has room
  always_comb begin
    state_n  = state;
    rr_n     = rr;
    owner_n  = owner;
    sel      = owner;
    found    = 1'b0;
    sel_data = 8'h00;
    sel_last = 1'b0;
    ready    = '0;
    push     = 1'b0;

    if (state == IDLE) begin
      for (int k = 0; k < int'(NREQ); k++) begin
        for (int i = 0; i < int'(NREQ); i++) begin
          if (!found && bus.req_valid[i] && (((int'(rr) + k) % int'(NREQ)) == i)) begin
            found = 1'b1;
            sel   = OW'(i);
          end
        end
      end
    end else begin
      found = bus.req_valid[owner];
    end

    for (int i = 0; i < int'(NREQ); i++) begin
      if (sel == OW'(i)) begin
        sel_data = bus.req_data[i*8 +: 8];
        sel_last = bus.req_last[i];
      end
    end

    if (found && push_ok) begin
      push    = 1'b1;
      ready   = NREQ'(1) << sel;
      owner_n = sel;
      if (state == IDLE || sel_last) rr_n = next_idx(sel);
      state_n = sel_last ? IDLE : LOCKED;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      rr    <= '0;
      owner <= '0;
    end else begin
      state <= state_n;
      rr    <= rr_n;
      owner <= owner_n;
    end
  end

  // FIFO pointers and occupancy; storage itself needs no reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + PW'(1);
      if (pop)  rd <= rd + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr] <= sel_data;
  end

  // RX holding register: load wins over ack so a same-cycle ack+load keeps valid high
  assign s_ready = ~rx_valid_q | bus.rx_ack;
  assign load    = bus.s_tvalid & s_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else if (load) begin
      rx_data_q  <= bus.s_tdata;
      rx_valid_q <= 1'b1;
    end else if (bus.rx_ack) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = ready;
  assign bus.m_tvalid  = (count != '0);
  assign bus.m_tdata   = (count != '0) ? mem[rd] : 8'h00;
  assign bus.s_tready  = s_ready;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.tx_count  = count;
  assign bus.tx_locked = (state == LOCKED);
  assign bus.tx_owner  = owner;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, round-robin, packet lock, FIFO full,
// RX backpressure and reset in the middle of a locked packet.
module tb_uart_tx_arbiter;
  localparam int unsigned NREQ  = 2;
  localparam int unsigned DEPTH = 4;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DEPTH(DEPTH)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.m_tready  = 1'b0;
    bus.s_tdata   = 8'h00;
    bus.s_tvalid  = 1'b0;
    bus.rx_ack    = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    n_rst = 1'b0;
    #3;
    vectors++; if (bus.tx_count !== 3'd0) begin miscompares++; $display("FAIL reset_tx_count: got %0d expected 0", bus.tx_count); end
    vectors++; if (bus.m_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_m_tvalid: got %b expected 0", bus.m_tvalid); end
    vectors++; if (bus.m_tdata !== 8'h00) begin miscompares++; $display("FAIL reset_m_tdata: got %h expected 00", bus.m_tdata); end
    vectors++; if (bus.tx_locked !== 1'b0) begin miscompares++; $display("FAIL reset_tx_locked: got %b expected 0", bus.tx_locked); end
    vectors++; if (bus.tx_owner !== 1'b0) begin miscompares++; $display("FAIL reset_tx_owner: got %0d expected 0", bus.tx_owner); end
    vectors++; if (bus.rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); end
    vectors++; if (bus.rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h expected 00", bus.rx_data); end
    vectors++; if (bus.s_tready !== 1'b1) begin miscompares++; $display("FAIL reset_s_tready: got %b expected 1", bus.s_tready); end
    vectors++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 00", bus.req_ready); end
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [7:0] exp_d [4] = '{8'h41, 8'h61, 8'h42, 8'h62};
    bus.req_valid = 2'b11;
    bus.req_last  = 2'b11;
    bus.m_tready  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.req_data = {8'h61 + 8'(k / 2), 8'h41 + 8'(k / 2)};
      if (k == 4) bus.req_valid = 2'b00;
      @(negedge clk);
      if (k < 4) begin
        vectors++; if (bus.req_ready !== exp_g[k]) begin miscompares++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, bus.req_ready, exp_g[k]); end
      end else begin
        vectors++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL rr_grant_idle: got %b expected 00", bus.req_ready); end
      end
      if (k > 0) begin
        vectors++; if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== exp_d[k-1]) begin miscompares++; $display("FAIL rr_tdata[%0d]: got v=%b d=%h expected v=1 d=%h", k, bus.m_tvalid, bus.m_tdata, exp_d[k-1]); end
      end
      next_cycle();
    end
    @(negedge clk);
    vectors++; if (bus.tx_count !== 3'd0 || bus.m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rr_drained: got cnt=%0d v=%b expected cnt=0 v=0", bus.tx_count, bus.m_tvalid); end
    next_cycle();
  endtask

  task automatic test_packet_lock();
    logic [1:0] v      [5] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b00};
    logic [7:0] d0     [5] = '{8'h41, 8'h42, 8'h43, 8'h00, 8'h00};
    logic       l0     [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] exp_g  [5] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
    logic       exp_l  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_o  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] exp_d  [5] = '{8'h00, 8'h41, 8'h42, 8'h43, 8'h31};
    bus.m_tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.req_valid = v[k];
      bus.req_data  = {8'h31, d0[k]};
      bus.req_last  = {1'b1, l0[k]};
      @(negedge clk);
      vectors++; if (bus.req_ready !== exp_g[k]) begin miscompares++; $display("FAIL lock_grant[%0d]: got %b expected %b", k, bus.req_ready, exp_g[k]); end
      vectors++; if (bus.tx_locked !== exp_l[k]) begin miscompares++; $display("FAIL lock_locked[%0d]: got %b expected %b", k, bus.tx_locked, exp_l[k]); end
      vectors++; if (bus.tx_owner !== exp_o[k]) begin miscompares++; $display("FAIL lock_owner[%0d]: got %0d expected %0d", k, bus.tx_owner, exp_o[k]); end
      if (k > 0) begin
        vectors++; if (bus.m_tdata !== exp_d[k]) begin miscompares++; $display("FAIL lock_tdata[%0d]: got %h expected %h", k, bus.m_tdata, exp_d[k]); end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_fifo_full();
    bus.m_tready  = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_last  = 2'b11;
    for (int k = 0; k < 5; k++) begin
      bus.req_data = {8'h00, 8'h41 + 8'(k)};
      @(negedge clk);
      vectors++; if (bus.tx_count !== 3'(k)) begin miscompares++; $display("FAIL full_count[%0d]: got %0d expected %0d", k, bus.tx_count, k); end
      vectors++; if (bus.req_ready !== ((k < 4) ? 2'b01 : 2'b00)) begin miscompares++; $display("FAIL full_ready[%0d]: got %b expected %b", k, bus.req_ready, (k < 4) ? 2'b01 : 2'b00); end
      next_cycle();
    end
    bus.m_tready = 1'b1;
    @(negedge clk);
    vectors++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL full_pop_noaccept: got %b expected 00", bus.req_ready); end
    vectors++; if (bus.m_tdata !== 8'h41 || bus.tx_count !== 3'd4) begin miscompares++; $display("FAIL full_pop_head: got d=%h cnt=%0d expected d=41 cnt=4", bus.m_tdata, bus.tx_count); end
    next_cycle();
    bus.m_tready = 1'b0;
    @(negedge clk);
    vectors++; if (bus.tx_count !== 3'd3 || bus.m_tdata !== 8'h42) begin miscompares++; $display("FAIL full_after_pop: got cnt=%0d d=%h expected cnt=3 d=42", bus.tx_count, bus.m_tdata); end
    vectors++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL full_reaccept: got %b expected 01", bus.req_ready); end
    next_cycle();
    bus.req_valid = 2'b00;
    bus.m_tready  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      vectors++; if (bus.m_tdata !== 8'h42 + 8'(j) || bus.tx_count !== 3'(4 - j)) begin miscompares++; $display("FAIL full_drain[%0d]: got d=%h cnt=%0d expected d=%h cnt=%0d", j, bus.m_tdata, bus.tx_count, 8'h42 + 8'(j), 4 - j); end
      next_cycle();
    end
    @(negedge clk);
    vectors++; if (bus.tx_count !== 3'd0 || bus.m_tvalid !== 1'b0) begin miscompares++; $display("FAIL full_empty: got cnt=%0d v=%b expected cnt=0 v=0", bus.tx_count, bus.m_tvalid); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_rx_backpressure();
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = 8'h55;
    @(negedge clk);
    vectors++; if (bus.s_tready !== 1'b1 || bus.rx_valid !== 1'b0) begin miscompares++; $display("FAIL rx_first_ready: got rdy=%b v=%b expected rdy=1 v=0", bus.s_tready, bus.rx_valid); end
    next_cycle();
    bus.s_tdata = 8'hAA;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h55 || bus.s_tready !== 1'b0) begin miscompares++; $display("FAIL rx_hold[%0d]: got v=%b d=%h rdy=%b expected v=1 d=55 rdy=0", k, bus.rx_valid, bus.rx_data, bus.s_tready); end
      next_cycle();
    end
    bus.rx_ack = 1'b1;
    @(negedge clk);
    vectors++; if (bus.s_tready !== 1'b1 || bus.rx_data !== 8'h55) begin miscompares++; $display("FAIL rx_ack_ready: got rdy=%b d=%h expected rdy=1 d=55", bus.s_tready, bus.rx_data); end
    next_cycle();
    bus.rx_ack   = 1'b0;
    bus.s_tvalid = 1'b0;
    @(negedge clk);
    vectors++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'hAA || bus.s_tready !== 1'b0) begin miscompares++; $display("FAIL rx_reload: got v=%b d=%h rdy=%b expected v=1 d=aa rdy=0", bus.rx_valid, bus.rx_data, bus.s_tready); end
    next_cycle();
    bus.rx_ack = 1'b1;
    next_cycle();
    @(negedge clk);
    vectors++; if (bus.rx_valid !== 1'b0 || bus.s_tready !== 1'b1 || bus.rx_data !== 8'hAA) begin miscompares++; $display("FAIL rx_cleared: got v=%b rdy=%b d=%h expected v=0 rdy=1 d=aa", bus.rx_valid, bus.s_tready, bus.rx_data); end
    next_cycle();
    @(negedge clk);
    vectors++; if (bus.rx_valid !== 1'b0) begin miscompares++; $display("FAIL rx_idle_ack: got v=%b expected 0", bus.rx_valid); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_mid_packet();
    bus.m_tready  = 1'b0;
    bus.req_valid = 2'b10;
    bus.req_last  = 2'b00;
    for (int k = 0; k < 3; k++) begin
      bus.req_data = {8'h71 + 8'(k), 8'h00};
      @(negedge clk);
      vectors++; if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL mid_grant[%0d]: got %b expected 10", k, bus.req_ready); end
      next_cycle();
    end
    @(negedge clk);
    vectors++; if (bus.tx_count !== 3'd3 || bus.tx_locked !== 1'b1 || bus.tx_owner !== 1'b1) begin miscompares++; $display("FAIL mid_before: got cnt=%0d lk=%b own=%0d expected cnt=3 lk=1 own=1", bus.tx_count, bus.tx_locked, bus.tx_owner); end
    #1;
    n_rst = 1'b0;
    #1;
    vectors++; if (bus.tx_count !== 3'd0 || bus.m_tvalid !== 1'b0 || bus.m_tdata !== 8'h00) begin miscompares++; $display("FAIL mid_reset_fifo: got cnt=%0d v=%b d=%h expected cnt=0 v=0 d=00", bus.tx_count, bus.m_tvalid, bus.m_tdata); end
    vectors++; if (bus.tx_locked !== 1'b0 || bus.tx_owner !== 1'b0) begin miscompares++; $display("FAIL mid_reset_lock: got lk=%b own=%0d expected lk=0 own=0", bus.tx_locked, bus.tx_owner); end
    @(posedge clk);
    #1;
    bus.req_valid = 2'b11;
    bus.req_last  = 2'b11;
    bus.req_data  = {8'h72, 8'h30};
    n_rst = 1'b1;
    @(negedge clk);
    vectors++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL mid_first_grant: got %b expected 01", bus.req_ready); end
    next_cycle();
    @(negedge clk);
    vectors++; if (bus.req_ready !== 2'b10 || bus.tx_count !== 3'd1 || bus.tx_locked !== 1'b0) begin miscompares++; $display("FAIL mid_second_grant: got g=%b cnt=%0d lk=%b expected g=10 cnt=1 lk=0", bus.req_ready, bus.tx_count, bus.tx_locked); end
    vectors++; if (bus.m_tdata !== 8'h30) begin miscompares++; $display("FAIL mid_tdata: got %h expected 30", bus.m_tdata); end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_fifo_full();
    test_rx_backpressure();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
